// File: rtl/exc_ctrl_pkg.sv
// rtl/exc_ctrl_pkg.sv - shared constants and types for the MEM-stage exception controller
package exc_ctrl_pkg;

    // CP0 register numbers that may be written back from MEM/WB
    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    // Cause.ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Status bit indices
    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;

    // exc_vec_i bit positions, bit 5 is the highest priority
    localparam int VEC_ADEL_IF = 5;
    localparam int VEC_RI      = 4;
    localparam int VEC_OV      = 3;
    localparam int VEC_SYS     = 2;
    localparam int VEC_BP      = 1;
    localparam int VEC_DATA    = 0;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } exc_state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - combinational priority encoder for interrupt, exceptions and ERET
//
// Ports:
//   int_i      interrupt condition (already masked by Status)
//   exc_vec_i  {adel_if, ri, ov, sys, bp, data_fault}
//   is_store_i data fault is a store
//   eret_i     ERET in the slot
//   hit_o      some event selected
//   exccode_o  ExcCode of the selected exception (0 for ERET)
//   is_eret_o  the selected event is ERET
module exc_prio_enc
    import exc_ctrl_pkg::*;
(
    input  logic       int_i,
    input  logic [5:0] exc_vec_i,
    input  logic       is_store_i,
    input  logic       eret_i,
    output logic       hit_o,
    output logic [4:0] exccode_o,
    output logic       is_eret_o
);

    always_comb begin
        hit_o     = 1'b1;
        exccode_o = EXC_INT;
        is_eret_o = 1'b0;
        if (int_i) begin
            exccode_o = EXC_INT;
        end else if (exc_vec_i[VEC_ADEL_IF]) begin
            exccode_o = EXC_ADEL;
        end else if (exc_vec_i[VEC_RI]) begin
            exccode_o = EXC_RI;
        end else if (exc_vec_i[VEC_OV]) begin
            exccode_o = EXC_OV;
        end else if (exc_vec_i[VEC_SYS]) begin
            exccode_o = EXC_SYS;
        end else if (exc_vec_i[VEC_BP]) begin
            exccode_o = EXC_BP;
        end else if (exc_vec_i[VEC_DATA]) begin
            exccode_o = is_store_i ? EXC_ADES : EXC_ADEL;
        end else if (eret_i) begin
            is_eret_o = 1'b1;
        end else begin
            hit_o = 1'b0;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - MEM-stage exception/interrupt controller with CP0 bypass and pipeline flush
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   valid_i, pc_i, in_ds_i   MEM-stage instruction slot
//   exc_vec_i, is_store_i    pending exception flags, data fault direction
//   bad_addr_i               faulting data address
//   eret_i                   ERET in MEM
//   status_i/cause_i/epc_i   live CP0 values
//   timer_int_i              CP0 timer interrupt
//   wb_cp0_*                 CP0 write in flight in MEM/WB (bypassed)
//   exc_pending_o            combinational event-selected flag
//   flush_o, new_pc_o        registered flush and redirect PC
//   cp0_*_o                  one-cycle exception-entry / ERET update to CP0
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic        in_ds_i,
    input  logic [5:0]  exc_vec_i,
    input  logic        is_store_i,
    input  logic [31:0] bad_addr_i,
    input  logic        eret_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        timer_int_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_wdata_i,
    output logic        exc_pending_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        cp0_exc_we_o,
    output logic [4:0]  cp0_exccode_o,
    output logic        cp0_bd_o,
    output logic [31:0] cp0_epc_o,
    output logic [31:0] cp0_badvaddr_o,
    output logic        cp0_eret_o
);

    exc_state_e  state_q, state_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic        exc_we_q, exc_we_d;
    logic [4:0]  exccode_q, exccode_d;
    logic        bd_q, bd_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        eret_q, eret_d;

    // Only the Status/Cause fields used for interrupt masking are bypassed.
    logic        wr_status, wr_cause, wr_epc;
    logic [7:0]  status_im, cause_ip;
    logic        status_ie, status_exl;
    logic [31:0] epc_eff;
    logic        int_cond;
    logic        hit, is_eret, sel;
    logic [4:0]  exccode;
    logic        unused_bits;

    assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

    assign wr_status  = wb_cp0_we_i && (wb_cp0_waddr_i == CP0_STATUS);
    assign wr_cause   = wb_cp0_we_i && (wb_cp0_waddr_i == CP0_CAUSE);
    assign wr_epc     = wb_cp0_we_i && (wb_cp0_waddr_i == CP0_EPC);

    assign status_im  = wr_status ? wb_cp0_wdata_i[15:8] : status_i[15:8];
    assign status_ie  = wr_status ? wb_cp0_wdata_i[STATUS_IE] : status_i[STATUS_IE];
    assign status_exl = wr_status ? wb_cp0_wdata_i[STATUS_EXL] : status_i[STATUS_EXL];
    // Only the software interrupt bits IP[1:0] are software-writable in Cause.
    assign cause_ip   = {cause_i[15] | timer_int_i, cause_i[14:10],
                         wr_cause ? wb_cp0_wdata_i[9:8] : cause_i[9:8]};
    assign epc_eff    = wr_epc ? wb_cp0_wdata_i : epc_i;

    assign int_cond   = status_ie && !status_exl && ((cause_ip & status_im) != 8'd0);

    exc_prio_enc u_prio (
        .int_i      (int_cond),
        .exc_vec_i  (exc_vec_i),
        .is_store_i (is_store_i),
        .eret_i     (eret_i),
        .hit_o      (hit),
        .exccode_o  (exccode),
        .is_eret_o  (is_eret)
    );

    // Instructions in the shadow of a flush are already dead, so IDLE gates everything.
    assign sel           = valid_i && (state_q == S_IDLE) && hit;
    assign exc_pending_o = sel;

    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        flush_d    = flush_q;
        new_pc_d   = new_pc_q;
        exc_we_d   = 1'b0;
        exccode_d  = exccode_q;
        bd_d       = bd_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        eret_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel) begin
                    state_d = S_FLUSH;
                    fcnt_d  = 3'(FLUSH_CYCLES - 1);
                    flush_d = 1'b1;
                    if (is_eret) begin
                        new_pc_d = epc_eff;
                        eret_d   = 1'b1;
                    end else begin
                        new_pc_d  = EXC_VECTOR;
                        exc_we_d  = 1'b1;
                        exccode_d = exccode;
                        bd_d      = in_ds_i;
                        epc_d     = in_ds_i ? pc_i - 32'd4 : pc_i;
                        // Code 4 with the fetch flag set can only come from the fetch fault.
                        if (exccode == EXC_ADEL && exc_vec_i[VEC_ADEL_IF]) begin
                            badvaddr_d = pc_i;
                        end else if (exccode == EXC_ADEL || exccode == EXC_ADES) begin
                            badvaddr_d = bad_addr_i;
                        end else begin
                            badvaddr_d = 32'd0;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (fcnt_q == 3'd0) begin
                    state_d = S_IDLE;
                    flush_d = 1'b0;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                flush_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            fcnt_q     <= 3'd0;
            flush_q    <= 1'b0;
            new_pc_q   <= 32'd0;
            exc_we_q   <= 1'b0;
            exccode_q  <= 5'd0;
            bd_q       <= 1'b0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            eret_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            flush_q    <= flush_d;
            new_pc_q   <= new_pc_d;
            exc_we_q   <= exc_we_d;
            exccode_q  <= exccode_d;
            bd_q       <= bd_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            eret_q     <= eret_d;
        end
    end

    assign flush_o        = flush_q;
    assign new_pc_o       = new_pc_q;
    assign cp0_exc_we_o   = exc_we_q;
    assign cp0_exccode_o  = exccode_q;
    assign cp0_bd_o       = bd_q;
    assign cp0_epc_o      = epc_q;
    assign cp0_badvaddr_o = badvaddr_q;
    assign cp0_eret_o     = eret_q;

endmodule
